// File: rtl/pb_event_classifier.sv
// Push-button gesture classifier.
// Turns debounced press/release pulses into short-press, long-press and
// double-click event pulses, plus a hold level while a long press is held.
// One shared timer measures either hold time or the gap after a release.
module pb_event_classifier #(
    parameter int LONG_CYCLES = 1000,
    parameter int GAP_CYCLES  = 300,
    parameter int CNT_WIDTH   = $clog2(((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed_pulse,
    input  logic released_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic hold_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HELD,
        S_LONG_HELD,
        S_WAIT_SECOND,
        S_SECOND_HELD
    } state_t;

    // Timer values on the edge that fires the long-press / gap-timeout transition
    localparam logic [CNT_WIDTH-1:0] LONG_LIM = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LIM  = CNT_WIDTH'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic                 short_press_q, short_press_d;
    logic                 long_press_q, long_press_d;
    logic                 double_click_q, double_click_d;
    logic                 hold_active_q, hold_active_d;

    // Saturating increment: the state machine leaves the timed state at its
    // limit, so saturation only guards against an unexpected stall.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // Next-state, timer and event decode
    always_comb begin
        state_d        = state_q;
        timer_d        = '0;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_click_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A lone release here is a leftover from a discarded gesture
                if (pressed_pulse) begin
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                // Release beats the long limit so a borderline press stays short
                if (released_pulse) begin
                    state_d = S_WAIT_SECOND;
                end else if (timer_q == LONG_LIM) begin
                    state_d      = S_LONG_HELD;
                    long_press_d = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (released_pulse) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_SECOND: begin
                // A press on the timeout edge still counts as a double click
                if (pressed_pulse) begin
                    state_d = S_SECOND_HELD;
                end else if (timer_q == GAP_LIM) begin
                    state_d       = S_IDLE;
                    short_press_d = 1'b1;
                end
            end
            S_SECOND_HELD: begin
                if (released_pulse) begin
                    state_d        = S_IDLE;
                    double_click_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timer restarts on every state change and only runs in timed states
        if (state_d == state_q && (state_q == S_HELD || state_q == S_WAIT_SECOND)) begin
            timer_d = sat_inc(timer_q);
        end

        hold_active_d = (state_d == S_LONG_HELD);
    end

    // State, timer and registered outputs; reset drops any gesture silently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_click_q <= 1'b0;
            hold_active_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_click_q <= double_click_d;
            hold_active_q  <= hold_active_d;
        end
    end

    assign short_press  = short_press_q;
    assign long_press   = long_press_q;
    assign double_click = double_click_q;
    assign hold_active  = hold_active_q;

endmodule

// File: tb/tb_pb_event_classifier.sv
// Directed bench for pb_event_classifier with LONG_CYCLES=8, GAP_CYCLES=4.
// Each step drives inputs for one posedge and checks the outputs just after it;
// expected outputs are packed as {hold_active, double_click, long_press, short_press}.
module tb_pb_event_classifier;

    logic clk;
    logic rst_n;
    logic pressed_pulse;
    logic released_pulse;
    logic short_press;
    logic long_press;
    logic double_click;
    logic hold_active;

    int checks;
    int failures;

    pb_event_classifier #(
        .LONG_CYCLES(8),
        .GAP_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pressed_pulse (pressed_pulse),
        .released_pulse(released_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .double_click  (double_click),
        .hold_active   (hold_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: drive inputs mid-cycle, sample outputs 1 time unit after the edge
    task automatic step(input logic rn, input logic p, input logic r,
                        input logic [3:0] exp, input string tag);
        logic [3:0] obs;
        @(negedge clk);
        rst_n          = rn;
        pressed_pulse  = p;
        released_pulse = r;
        @(posedge clk);
        #1;
        obs = {hold_active, double_click, long_press, short_press};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Quiet edges where no output may be active
    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'b0000, tag);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        pressed_pulse  = 1'b0;
        released_pulse = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 4'b0000, "reset0");
        step(1'b0, 1'b1, 1'b0, 4'b0000, "reset_press_ignored");
        quiet(2, "post_reset_idle");

        // Stray release in IDLE does nothing
        step(1'b1, 1'b0, 1'b1, 4'b0000, "idle_stray_release");
        quiet(6, "idle_stray_after");

        // 1. Short press: press e0, release e3, short after e7
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s1_e0_press");
        quiet(2, "s1_e1_e2");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s1_e3_release");
        quiet(3, "s1_e4_e6");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "s1_e7_short");
        quiet(3, "s1_after");

        // 2. Long press: long after e8, hold through e12; stray press at e10
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s2_e0_press");
        quiet(7, "s2_e1_e7");
        step(1'b1, 1'b0, 1'b0, 4'b1010, "s2_e8_long");
        step(1'b1, 1'b0, 1'b0, 4'b1000, "s2_e9_hold");
        step(1'b1, 1'b1, 1'b0, 4'b1000, "s2_e10_press_in_long");
        step(1'b1, 1'b0, 1'b0, 4'b1000, "s2_e11_hold");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s2_e12_release");
        quiet(6, "s2_after_no_short");

        // 3. Double click: press e0, release e2, press e4, release e6
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s3_e0_press");
        step(1'b1, 1'b0, 1'b0, 4'b0000, "s3_e1");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s3_e2_release");
        step(1'b1, 1'b0, 1'b0, 4'b0000, "s3_e3");
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s3_e4_press2");
        step(1'b1, 1'b0, 1'b0, 4'b0000, "s3_e5");
        step(1'b1, 1'b0, 1'b1, 4'b0100, "s3_e6_double");
        quiet(6, "s3_after_no_short");

        // 4a. Release exactly on the long-limit edge takes the short path
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s4a_e0_press");
        quiet(7, "s4a_e1_e7");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s4a_e8_release_no_long");
        quiet(3, "s4a_e9_e11");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "s4a_e12_short");
        quiet(2, "s4a_after");

        // 4b. Second press exactly on the gap-timeout edge forms a double click
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s4b_e0_press");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s4b_e1_release");
        quiet(3, "s4b_e2_e4");
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s4b_e5_press_on_timeout");
        step(1'b1, 1'b0, 1'b0, 4'b0000, "s4b_e6");
        step(1'b1, 1'b0, 1'b1, 4'b0100, "s4b_e7_double");
        quiet(6, "s4b_after_no_short");

        // 5. Reset mid-gesture discards it; release after reset is ignored
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s5_e0_press");
        quiet(2, "s5_e1_e2");
        step(1'b0, 1'b0, 1'b0, 4'b0000, "s5_e3_reset");
        step(1'b1, 1'b0, 1'b0, 4'b0000, "s5_e4");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s5_e5_release_ignored");
        quiet(10, "s5_after_quiet");

        // 5b. Next gesture after reset classifies normally
        step(1'b1, 1'b1, 1'b0, 4'b0000, "s5b_f0_press");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "s5b_f1_release");
        quiet(3, "s5b_f2_f4");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "s5b_f5_short");
        quiet(2, "s5b_after");

        // Both pulses in IDLE: press wins, then a normal short press follows
        step(1'b1, 1'b1, 1'b1, 4'b0000, "both_g0_idle_press_wins");
        step(1'b1, 1'b0, 1'b1, 4'b0000, "both_g1_release");
        quiet(3, "both_g2_g4");
        step(1'b1, 1'b0, 1'b0, 4'b0001, "both_g5_short");
        quiet(2, "both_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
